// File: rtl/cic_decimator_if.sv
// Sample stream bus between the mixer and the CIC decimator.
// The master drives the input stream; the slave (decimator) returns the decimated stream.
interface cic_decimator_if #(
  parameter int DIN_W  = 20,
  parameter int DOUT_W = 20
) ();
  logic signed [DIN_W-1:0]  din;
  logic                     din_valid;
  logic signed [DOUT_W-1:0] dout;
  logic                     dout_valid;

  modport master (output din, output din_valid, input dout, input dout_valid);
  modport slave  (input din, input din_valid, output dout, output dout_valid);
endinterface

// File: rtl/cic_decimator.sv
// 3-stage CIC decimator (R = 2^R_LOG2, differential delay 1) with an arithmetic-shift output scaler.
// Optional OUT_ROUND_EN: round-half-up output with positive saturation instead of plain truncation.
module cic_decimator #(
  parameter int DIN_W  = 20,
  parameter int DOUT_W = 20,
  parameter int R_LOG2 = 3
) (
  input  logic           i_clk,
  input  logic           i_rst,
  cic_decimator_if.slave io_bus
);
  localparam int SH    = 3 * R_LOG2;
  localparam int ACC_W = DIN_W + SH;

  logic signed [ACC_W-1:0] r_i1, r_i2, r_i3;
  logic signed [ACC_W-1:0] r_comb_in;
  logic signed [ACC_W-1:0] r_x1, r_x2, r_x3;
  logic signed [ACC_W-1:0] r_c1, r_c2, r_c3;
  logic        [R_LOG2-1:0] r_phase;
  logic        [3:0]        r_tag;
  logic signed [DOUT_W-1:0] r_dout;
  logic                     r_dout_valid;

  logic signed [ACC_W-1:0]  w_din_ext, w_i1, w_i2, w_i3;
  logic                     w_strobe;
  logic signed [DOUT_W-1:0] w_dout;

  // Same-edge integrator chain; modulo wrap is harmless because the combs undo it.
  assign w_din_ext = {{SH{io_bus.din[DIN_W-1]}}, io_bus.din};
  assign w_i1      = r_i1 + w_din_ext;
  assign w_i2      = r_i2 + w_i1;
  assign w_i3      = r_i3 + w_i2;
  assign w_strobe  = io_bus.din_valid && (r_phase == '1);

`ifdef OUT_ROUND_EN
  localparam logic signed [DIN_W:0] DOUT_MAX = (DIN_W+1)'((2 ** (DOUT_W - 1)) - 1);
  logic signed [ACC_W:0] w_rnd_sum;
  logic signed [DIN_W:0] w_rnd_q;
  logic                  unused_rnd_low;

  // One guard bit keeps the half-LSB add from wrapping near +max.
  assign w_rnd_sum      = {r_c3[ACC_W-1], r_c3} + (ACC_W+1)'(2 ** (SH - 1));
  assign w_rnd_q        = w_rnd_sum[ACC_W:SH];
  assign unused_rnd_low = ^w_rnd_sum[SH-1:0];
  assign w_dout         = (w_rnd_q > DOUT_MAX) ? DOUT_MAX[DOUT_W-1:0] : w_rnd_q[DOUT_W-1:0];
`else
  logic unused_trunc_low;

  assign w_dout           = r_c3[SH +: DOUT_W];
  assign unused_trunc_low = ^r_c3[SH-1:0];
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_i1         <= '0;
      r_i2         <= '0;
      r_i3         <= '0;
      r_comb_in    <= '0;
      r_x1         <= '0;
      r_x2         <= '0;
      r_x3         <= '0;
      r_c1         <= '0;
      r_c2         <= '0;
      r_c3         <= '0;
      r_phase      <= '0;
      r_tag        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      if (io_bus.din_valid) begin
        r_i1    <= w_i1;
        r_i2    <= w_i2;
        r_i3    <= w_i3;
        r_phase <= r_phase + R_LOG2'(1);
      end
      if (w_strobe) r_comb_in <= w_i3;
      // Strobe tag walks the comb pipeline one stage per clock, independent of din_valid.
      r_tag <= {r_tag[2:0], w_strobe};
      if (r_tag[0]) begin
        r_x1 <= r_comb_in;
        r_c1 <= r_comb_in - r_x1;
      end
      if (r_tag[1]) begin
        r_x2 <= r_c1;
        r_c2 <= r_c1 - r_x2;
      end
      if (r_tag[2]) begin
        r_x3 <= r_c2;
        r_c3 <= r_c2 - r_x3;
      end
      if (r_tag[3]) r_dout <= w_dout;
      r_dout_valid <= r_tag[3];
    end
  end

  assign io_bus.dout       = r_dout;
  assign io_bus.dout_valid = r_dout_valid;
endmodule
